uart_rx_fifo: RTL and testbench

//  Parametrised UART receiver: 8N1 generalised to 5..9 data bits, none/odd/even parity, 1 or 2 stop bits.
//  Rx is oversampled with a 3-sample majority vote at mid-bit, and received words are buffered in a FIFO.

---
 rtl/uart_rx_fifo_if.sv | 28 ++
 rtl/uart_rx_fifo.sv | 233 +++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Read-side bundle of the UART receiver: FIFO pop handshake, occupancy and
// the one-cycle status pulses. The receiver uses the slave view and the
// consumer logic uses the master view.
interface uart_rx_fifo_if #(
   parameter int DATA_SIZE  = 8,
   parameter int FIFO_DEPTH = 16
);
   logic                          rd_en;
   logic                          rd_valid;
   logic [DATA_SIZE-1:0]          rd_data;
   logic [$clog2(FIFO_DEPTH):0]   fifo_count;
   logic                          parity_err;
   logic                          frame_err;
   logic                          break_det;
   logic                          overrun;

   modport slave (
      input  rd_en,
      output rd_valid, rd_data, fifo_count,
             parity_err, frame_err, break_det, overrun
   );

   modport master (
      output rd_en,
      input  rd_valid, rd_data, fifo_count,
             parity_err, frame_err, break_det, overrun
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample mid-bit majority vote and a first-word-fall-
// through FIFO. Supports 5..9 data bits, none/odd/even parity and 1 or 2
// stop bits. Errors, line break and FIFO overrun are reported as pulses.
module uart_rx_fifo #(
   parameter int SYS_FREQ   = 50000000,
   parameter int BAUD_RATE  = 9600,
   parameter int DATA_SIZE  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_SIZE  = 1,
   parameter int SAMPLE     = 16,
   parameter int FIFO_DEPTH = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              Rx,
   uart_rx_fifo_if.slave     rd_if
);

   localparam int DIV_RAW = SYS_FREQ / (BAUD_RATE * SAMPLE);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int DIV_W   = $clog2(DIV + 1);
   localparam int TICK_W  = $clog2(SAMPLE);
   localparam int M       = SAMPLE / 2;
   localparam int BIT_W   = $clog2(DATA_SIZE);
   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int CW      = AW + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   state_t               r_state;
   logic                 r_rxMeta;
   logic                 r_rxSync;
   logic                 r_rxPrev;
   logic [DIV_W-1:0]     r_divCnt;
   logic [TICK_W-1:0]    r_tickCnt;
   logic                 r_s0;
   logic                 r_s1;
   logic [DATA_SIZE-1:0] r_shift;
   logic [BIT_W-1:0]     r_bitIdx;
   logic                 r_parBit;
   logic                 r_stopIdx;
   logic                 r_stopErr;
   logic                 r_stopAll0;
   logic                 r_parityErr;
   logic                 r_frameErr;
   logic                 r_breakDet;
   logic                 r_overrun;

   logic [DATA_SIZE-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]        r_wrPtr;
   logic [AW-1:0]        r_rdPtr;
   logic [CW-1:0]        r_count;

   logic w_startEdge;
   logic w_tick;
   logic w_voteNow;
   logic w_vote;
   logic w_lastStop;
   logic w_break;
   logic w_frameErr;
   logic w_parErr;
   logic w_push;
   logic w_pop;
   logic w_full;
   logic w_wrOk;

   // A falling edge is only a start bit when the receiver is idle.
   assign w_startEdge = (r_state == S_IDLE) && r_rxPrev && !r_rxSync;
   assign w_tick      = (r_divCnt == DIV_W'(1));
   assign w_voteNow   = w_tick && (r_tickCnt == TICK_W'(M + 1));
   assign w_vote      = (r_s0 & r_s1) | (r_s0 & r_rxSync) | (r_s1 & r_rxSync);
   assign w_lastStop  = (r_state == S_STOP) && (r_stopIdx == 1'(STOP_SIZE - 1));

   // Frame outcome, evaluated with the vote of the last stop bit.
   assign w_break    = (r_shift == '0) && ((PARITY == 0) || !r_parBit) &&
                       r_stopAll0 && !w_vote;
   assign w_frameErr = r_stopErr || !w_vote;
   assign w_parErr   = (PARITY != 0) &&
                       ((^r_shift ^ r_parBit) != (PARITY == 1));
   assign w_push     = w_voteNow && w_lastStop && !w_break &&
                       !w_frameErr && !w_parErr;

   assign w_pop  = rd_if.rd_en && (r_count != '0);
   assign w_full = (r_count == CW'(FIFO_DEPTH));
   assign w_wrOk = w_push && (!w_full || w_pop);

   assign rd_if.rd_valid   = (r_count != '0);
   assign rd_if.rd_data    = r_mem[r_rdPtr];
   assign rd_if.fifo_count = r_count;
   assign rd_if.parity_err = r_parityErr;
   assign rd_if.frame_err  = r_frameErr;
   assign rd_if.break_det  = r_breakDet;
   assign rd_if.overrun    = r_overrun;

   // Two-flop synchroniser for the asynchronous Rx pin plus an edge-detect flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rxMeta <= 1'b1;
         r_rxSync <= 1'b1;
         r_rxPrev <= 1'b1;
      end else begin
         r_rxMeta <= Rx;
         r_rxSync <= r_rxMeta;
         r_rxPrev <= r_rxSync;
      end
   end

   // Baud divider, oversampling tick index and the two early vote samples;
   // the start edge realigns all of them to the new frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_divCnt  <= DIV_W'(1);
         r_tickCnt <= '0;
         r_s0      <= 1'b1;
         r_s1      <= 1'b1;
      end else if (w_startEdge) begin
         r_divCnt  <= DIV_W'(DIV);
         r_tickCnt <= '0;
      end else begin
         r_divCnt <= w_tick ? DIV_W'(DIV) : r_divCnt - DIV_W'(1);
         if (w_tick) begin
            r_tickCnt <= (r_tickCnt == TICK_W'(SAMPLE - 1)) ? '0 : r_tickCnt + TICK_W'(1);
            if (r_tickCnt == TICK_W'(M - 1)) r_s0 <= r_rxSync;
            if (r_tickCnt == TICK_W'(M))     r_s1 <= r_rxSync;
         end
      end
   end

   // Frame FSM: each state consumes one voted bit; status pulses are registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_shift     <= '0;
         r_bitIdx    <= '0;
         r_parBit    <= 1'b0;
         r_stopIdx   <= 1'b0;
         r_stopErr   <= 1'b0;
         r_stopAll0  <= 1'b1;
         r_parityErr <= 1'b0;
         r_frameErr  <= 1'b0;
         r_breakDet  <= 1'b0;
      end else begin
         r_parityErr <= 1'b0;
         r_frameErr  <= 1'b0;
         r_breakDet  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_startEdge) r_state <= S_START;
            end
            S_START: begin
               if (w_voteNow) begin
                  if (!w_vote) begin
                     r_state    <= S_DATA;
                     r_bitIdx   <= '0;
                     r_parBit   <= 1'b0;
                     r_stopErr  <= 1'b0;
                     r_stopAll0 <= 1'b1;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end
            S_DATA: begin
               if (w_voteNow) begin
                  r_shift <= {w_vote, r_shift[DATA_SIZE-1:1]};
                  if (r_bitIdx == BIT_W'(DATA_SIZE - 1)) begin
                     r_state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                     r_stopIdx <= 1'b0;
                  end else begin
                     r_bitIdx <= r_bitIdx + BIT_W'(1);
                  end
               end
            end
            S_PARITY: begin
               if (w_voteNow) begin
                  r_parBit  <= w_vote;
                  r_stopIdx <= 1'b0;
                  r_state   <= S_STOP;
               end
            end
            S_STOP: begin
               if (w_voteNow) begin
                  if (w_lastStop) begin
                     if (w_break)         r_breakDet  <= 1'b1;
                     else if (w_frameErr) r_frameErr  <= 1'b1;
                     else if (w_parErr)   r_parityErr <= 1'b1;
                     r_state <= w_vote ? S_IDLE : S_WAIT_HIGH;
                  end else begin
                     r_stopErr  <= r_stopErr | !w_vote;
                     r_stopAll0 <= r_stopAll0 & !w_vote;
                     r_stopIdx  <= 1'b1;
                  end
               end
            end
            S_WAIT_HIGH: begin
               if (r_rxSync) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // FIFO storage and pointers; a full FIFO only takes a word alongside a pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrPtr   <= '0;
         r_rdPtr   <= '0;
         r_count   <= '0;
         r_overrun <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      end else begin
         r_overrun <= w_push && w_full && !w_pop;
         if (w_wrOk) begin
            r_mem[r_wrPtr] <= r_shift;
            r_wrPtr        <= r_wrPtr + AW'(1);
         end
         if (w_pop) r_rdPtr <= r_rdPtr + AW'(1);
         case ({w_wrOk, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo. Three receivers with different frame
// formats share one clock (DIV = 1, 16 clocks per bit). Stimulus pushes the
// expected words, status pulses and snapshot checks into queues; a monitor
// process compares them against what the receivers present.
module tb_uart_rx_fifo;

   localparam int BIT_CLKS = 16;
   localparam int K_PAR = 0, K_FRAME = 1, K_BREAK = 2, K_OVR = 3;
   localparam int F_COUNT = 0, F_VALID = 1, F_PULSE = 2, F_WLEFT = 3, F_SLEFT = 4;

   typedef struct {
      int    unit;
      int    field;
      int    expv;
      string name;
   } chk_t;

   logic       clk;
   logic [2:0] rstn;
   logic [2:0] rx;
   logic [2:0] ren;

   int vectors;
   int miscompares;

   logic [8:0] expWord [3][$];
   int         expStat [3][$];
   chk_t       chkQ [$];

   logic [8:0] mData  [3];
   logic [2:0] mValid;
   logic [3:0] mPulse [3];
   logic [4:0] mCount [3];

   uart_rx_fifo_if #(.DATA_SIZE(8), .FIFO_DEPTH(4))  if0 ();
   uart_rx_fifo_if #(.DATA_SIZE(8), .FIFO_DEPTH(16)) if1 ();
   uart_rx_fifo_if #(.DATA_SIZE(9), .FIFO_DEPTH(16)) if2 ();

   uart_rx_fifo #(.SYS_FREQ(1843200), .BAUD_RATE(115200), .DATA_SIZE(8),
                  .PARITY(0), .STOP_SIZE(1), .SAMPLE(16), .FIFO_DEPTH(4))
      u0 (.clk(clk), .rst_n(rstn[0]), .Rx(rx[0]), .rd_if(if0.slave));

   uart_rx_fifo #(.SYS_FREQ(1843200), .BAUD_RATE(115200), .DATA_SIZE(8),
                  .PARITY(2), .STOP_SIZE(1), .SAMPLE(16), .FIFO_DEPTH(16))
      u1 (.clk(clk), .rst_n(rstn[1]), .Rx(rx[1]), .rd_if(if1.slave));

   uart_rx_fifo #(.SYS_FREQ(1843200), .BAUD_RATE(115200), .DATA_SIZE(9),
                  .PARITY(1), .STOP_SIZE(2), .SAMPLE(16), .FIFO_DEPTH(16))
      u2 (.clk(clk), .rst_n(rstn[2]), .Rx(rx[2]), .rd_if(if2.slave));

   assign if0.rd_en = ren[0];
   assign if1.rd_en = ren[1];
   assign if2.rd_en = ren[2];

   assign mData[0]  = {1'b0, if0.rd_data};
   assign mData[1]  = {1'b0, if1.rd_data};
   assign mData[2]  = if2.rd_data;
   assign mValid    = {if2.rd_valid, if1.rd_valid, if0.rd_valid};
   assign mCount[0] = {2'b00, if0.fifo_count};
   assign mCount[1] = if1.fifo_count;
   assign mCount[2] = if2.fifo_count;
   assign mPulse[0] = {if0.overrun, if0.break_det, if0.frame_err, if0.parity_err};
   assign mPulse[1] = {if1.overrun, if1.break_det, if1.frame_err, if1.parity_err};
   assign mPulse[2] = {if2.overrun, if2.break_det, if2.frame_err, if2.parity_err};

   // Free-running 10-unit clock shared by all three receivers.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case some wait never resolves.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   // Monitor: away from the active edge, compare popped words, any status
   // pulse, and queued snapshot checks against the scoreboard.
   always @(negedge clk) begin
      for (int u = 0; u < 3; u++) begin
         if (ren[u] && mValid[u]) begin
            vectors++;
            if (expWord[u].size() == 0) begin
               miscompares++;
               $display("[TB] FAIL word u%0d: popped 0x%03h, required no word", u, mData[u]);
            end else begin
               logic [8:0] e;
               e = expWord[u].pop_front();
               if (mData[u] !== e) begin
                  miscompares++;
                  $display("[TB] FAIL word u%0d: got 0x%03h, required 0x%03h", u, mData[u], e);
               end
            end
         end
         for (int b = 0; b < 4; b++) begin
            if (mPulse[u][b]) begin
               vectors++;
               if (expStat[u].size() == 0) begin
                  miscompares++;
                  $display("[TB] FAIL status u%0d: pulse kind %0d, required no pulse", u, b);
               end else begin
                  int k;
                  k = expStat[u].pop_front();
                  if (k != b) begin
                     miscompares++;
                     $display("[TB] FAIL status u%0d: pulse kind %0d, required kind %0d", u, b, k);
                  end
               end
            end
         end
      end
      while (chkQ.size() > 0) begin
         chk_t c;
         int   act;
         c = chkQ.pop_front();
         case (c.field)
            F_COUNT: act = int'(mCount[c.unit]);
            F_VALID: act = int'(mValid[c.unit]);
            F_PULSE: act = int'(mPulse[c.unit]);
            F_WLEFT: act = expWord[c.unit].size();
            F_SLEFT: act = expStat[c.unit].size();
            default: act = -1;
         endcase
         vectors++;
         if (act != c.expv) begin
            miscompares++;
            $display("[TB] FAIL %s u%0d: got %0d, required %0d", c.name, c.unit, act, c.expv);
         end
      end
   end

   // Queue a snapshot check; the monitor evaluates it at the next falling edge.
   task automatic checkOutput(input int u, input int field, input int expv, input string name);
      chk_t c;
      c.unit  = u;
      c.field = field;
      c.expv  = expv;
      c.name  = name;
      chkQ.push_back(c);
      @(posedge clk);
   endtask

   // Drive one serial frame: start bit, data LSB first, optional parity bit
   // (par < 0 means none), then nStop stop bits taken from stops LSB first.
   task automatic applyStimulus(input int u, input logic [8:0] data, input int nData,
                                input int par, input logic [1:0] stops, input int nStop);
      logic [15:0] bits;
      int          n;
      bits = '0;
      n    = 1;
      for (int i = 0; i < nData; i++) begin
         bits[n] = data[i];
         n++;
      end
      if (par >= 0) begin
         bits[n] = par[0];
         n++;
      end
      for (int i = 0; i < nStop; i++) begin
         bits[n] = stops[i];
         n++;
      end
      for (int i = 0; i < n; i++) begin
         rx[u] = bits[i];
         repeat (BIT_CLKS) @(posedge clk);
      end
      rx[u] = 1'b1;
      repeat (4) @(posedge clk);
   endtask

   // Pop one word once the receiver offers one; a missing word is left in
   // the scoreboard and shows up in the final drain check.
   task automatic popOne(input int u);
      int t;
      t = 0;
      while (!mValid[u] && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (mValid[u]) begin
         @(posedge clk);
         #1 ren[u] = 1'b1;
         @(posedge clk);
         #1 ren[u] = 1'b0;
      end
   endtask

   // Directed sequence.
   initial begin
      vectors     = 0;
      miscompares = 0;
      rstn = 3'b000;
      rx   = 3'b111;
      ren  = 3'b000;
      repeat (3) @(posedge clk);
      for (int u = 0; u < 3; u++) begin
         checkOutput(u, F_COUNT, 0, "reset count");
         checkOutput(u, F_VALID, 0, "reset valid");
         checkOutput(u, F_PULSE, 0, "reset pulses");
      end
      #1 rstn = 3'b111;
      repeat (5) @(posedge clk);

      // 8N1 basic word, then pop.
      expWord[0].push_back(9'h0A5);
      applyStimulus(0, 9'h0A5, 8, -1, 2'b01, 1);
      checkOutput(0, F_VALID, 1, "a5 valid");
      checkOutput(0, F_COUNT, 1, "a5 count");
      popOne(0);
      checkOutput(0, F_VALID, 0, "a5 popped valid");
      checkOutput(0, F_COUNT, 0, "a5 popped count");

      // Stop bit 0 -> frame error, then a good frame.
      expStat[0].push_back(K_FRAME);
      applyStimulus(0, 9'h03C, 8, -1, 2'b00, 1);
      checkOutput(0, F_COUNT, 0, "frame err no write");
      expWord[0].push_back(9'h055);
      applyStimulus(0, 9'h055, 8, -1, 2'b01, 1);
      popOne(0);

      // Line break for 20 bit times, then a normal frame.
      expStat[0].push_back(K_BREAK);
      rx[0] = 1'b0;
      repeat (20 * BIT_CLKS) @(posedge clk);
      rx[0] = 1'b1;
      repeat (2 * BIT_CLKS) @(posedge clk);
      checkOutput(0, F_COUNT, 0, "break no write");
      expWord[0].push_back(9'h081);
      applyStimulus(0, 9'h081, 8, -1, 2'b01, 1);
      popOne(0);

      // Five frames into a 4-deep FIFO without popping.
      for (int i = 1; i <= 5; i++) begin
         if (i <= 4) expWord[0].push_back(9'(i));
         else        expStat[0].push_back(K_OVR);
         applyStimulus(0, 9'(i), 8, -1, 2'b01, 1);
      end
      checkOutput(0, F_COUNT, 4, "full count");
      for (int i = 0; i < 4; i++) popOne(0);
      checkOutput(0, F_COUNT, 0, "drained count");

      // Short low glitch on an idle line.
      rx[0] = 1'b0;
      repeat (6) @(posedge clk);
      rx[0] = 1'b1;
      repeat (3 * BIT_CLKS) @(posedge clk);
      checkOutput(0, F_COUNT, 0, "glitch count");
      checkOutput(0, F_VALID, 0, "glitch valid");

      // Reset in the middle of data bit 3 while one word is buffered.
      applyStimulus(0, 9'h042, 8, -1, 2'b01, 1);
      checkOutput(0, F_COUNT, 1, "pre-reset count");
      rx[0] = 1'b0;
      repeat (BIT_CLKS) @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         rx[0] = i[0] ? 1'b1 : 1'b0;
         repeat (BIT_CLKS) @(posedge clk);
      end
      rx[0] = 1'b1;
      repeat (BIT_CLKS / 2) @(posedge clk);
      #1 rstn[0] = 1'b0;
      repeat (2) @(posedge clk);
      checkOutput(0, F_COUNT, 0, "mid-reset count");
      checkOutput(0, F_VALID, 0, "mid-reset valid");
      checkOutput(0, F_PULSE, 0, "mid-reset pulses");
      #1 rstn[0] = 1'b1;
      repeat (3 * BIT_CLKS) @(posedge clk);
      checkOutput(0, F_COUNT, 0, "post-reset count");
      expWord[0].push_back(9'h07E);
      applyStimulus(0, 9'h07E, 8, -1, 2'b01, 1);
      popOne(0);

      // Even parity: 0x03 needs parity 0, send 1; then 0x07 with parity 1.
      expStat[1].push_back(K_PAR);
      applyStimulus(1, 9'h003, 8, 1, 2'b01, 1);
      checkOutput(1, F_COUNT, 0, "parity err no write");
      expWord[1].push_back(9'h007);
      applyStimulus(1, 9'h007, 8, 1, 2'b01, 1);
      checkOutput(1, F_COUNT, 1, "even good count");
      popOne(1);

      // 9 data bits, odd parity, 2 stop bits: 0x1FF has nine ones -> parity 0.
      expWord[2].push_back(9'h1FF);
      applyStimulus(2, 9'h1FF, 9, 0, 2'b11, 2);
      checkOutput(2, F_COUNT, 1, "9o2 count");
      popOne(2);
      // First stop bit 0, second 1 -> frame error (0x0A5 has four ones -> parity 1).
      expStat[2].push_back(K_FRAME);
      applyStimulus(2, 9'h0A5, 9, 1, 2'b10, 2);
      checkOutput(2, F_COUNT, 0, "first stop err no write");

      repeat (20) @(posedge clk);
      for (int u = 0; u < 3; u++) begin
         checkOutput(u, F_WLEFT, 0, "words left");
         checkOutput(u, F_SLEFT, 0, "pulses left");
      end
      for (int t = 0; t < 10 && chkQ.size() > 0; t++) @(posedge clk);
      @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
